sprite_draw_scheduler: RTL and testbench
========================================

// Module: sprite_draw_scheduler
// PURPOSE
//   Arbitrates two sprite-draw requesters (req 0 = note display, req 1 = BPM display)
//   and sequences the shared image ROM bank for the granted request.
//   For each grant it scans the selected image ROM row-major and absorbs the
//   1-cycle ROM read latency. It emits one pixel per cycle to the VGA adapter
//   (x, y, colour, plot).
//   It sits between the display FSMs and the memory_controller / vga_adapter pair.
// PARAMETERS
//   SPR_W     160  sprite width in pixels (columns per ROM row)
//   SPR_H     120  sprite height in pixels; SPR_W*SPR_H must be <= 32768
//   SCREEN_W  160  visible width; pixels with x >= SCREEN_W are not plotted
//   SCREEN_H  120  visible height; pixels with y >= SCREEN_H are not plotted
// PORTS
//   clk         in   1   system clock; all logic is on the rising edge
//   resetn      in   1   synchronous reset, active low
//   req         in   2   draw request per requester; held high until ack
//   sel0/sel1   in   8   ROM chip-select code per requester (0 black, 1..11 notes, 13..19 BPM)
//   x0/x1       in   8   sprite origin x per requester
//   y0/y1       in   7   sprite origin y per requester
//   ack         out  2   1-cycle completion pulse to the granted requester
//   busy        out  1   high from the grant cycle through the DONE cycle
//   mem_addr    out  15  ROM address to memory_controller
//   chip_sel    out  8   ROM select to memory_controller
//   mem_q       in   3   ROM data; valid 1 cycle after mem_addr/chip_sel
//   vga_x       out  8   pixel x to vga_adapter
//   vga_y       out  7   pixel y to vga_adapter
//   vga_colour  out  3   pixel colour (= mem_q)
//   plot        out  1   pixel write strobe
// BEHAVIOUR
//   Reset: state=IDLE; ack, busy, plot = 0; mem_addr, chip_sel, vga_x, vga_y and vga_colour = 0.
//     last_grant = 1, so requester 0 wins the first tie.
//   Reset mid-draw: at the next edge plot=0 and ack=0, and the FSM returns to IDLE.
//     The aborted request is not acked; the requester must hold or reassert req.
//   IDLE: on an edge where req != 0, grant one requester:
//     - only one bit set -> grant that requester;
//     - both bits set -> grant the requester that is not last_grant (round robin).
//     - On grant: latch sel/x/y of the winner, set col=row=0 and addr=0, busy=1, go to DRAW.
//   DRAW: each cycle drive mem_addr=addr and chip_sel=latched sel.
//     - addr increments by 1 each cycle (running counter, no multiplier).
//     - col wraps from SPR_W-1 to 0 and then increments row.
//     - col and row are delayed 1 cycle alongside the ROM access.
//     - When col=SPR_W-1 and row=SPR_H-1 are issued, go to FLUSH.
//   Pixel stage, 1-cycle latency after each DRAW address:
//     - vga_x = ox + col_d (8-bit add), vga_y = oy + row_d (7-bit add), vga_colour = mem_q.
//     - plot = 1 only if the full-width sums are < SCREEN_W and < SCREEN_H, else plot = 0.
//   FLUSH: 1 cycle; the pixel stage plots the last pixel; mem_addr holds.
//   DONE: 1 cycle; ack[grant]=1, last_grant=grant, plot=0; go to IDLE.
//     busy falls on the edge into IDLE.
//   IDLE outputs: chip_sel=0, mem_addr=0, plot=0.
//   Handshake rules:
//     - A requester keeps sel/x/y stable from req rise until ack; changes mid-draw are ignored.
//     - req still high in the cycle after ack counts as a new request.
//     - A request that arrives during busy waits; there is no queue depth beyond req levels.
//   Draw timing: req seen at edge N gives ack high in cycle N+SPR_W*SPR_H+2.
//     There are exactly SPR_W*SPR_H plot cycles minus any clipped pixels.
//   Back-to-back: at least 1 IDLE cycle separates consecutive draws.
// TESTING
//   (Test params SPR_W=4, SPR_H=2; ROM model returns addr[2:0] after a 1-cycle delay.)
//   T1 single draw:
//     req=01, sel0=5, x0=10, y0=20
//     -> chip_sel=5 for 8 cycles; plot pixels (10,20)..(13,21) with colours 0..7
//     -> ack=01 exactly once; busy low after.
//   T2 tie and round robin:
//     req=11 from reset -> requester 0 drawn first, then requester 1.
//     Both still high -> requester 0 next.
//   T3 clipping:
//     x0=158, y0=119 -> only (158,119) and (159,119) plotted; ack still issued.
//   T4 reset mid-draw:
//     resetn=0 at the 3rd plot -> plot=0 and busy=0 next cycle, no ack.
//     After resetn=1 with req held -> full redraw from (x0,y0).
//   T5 late request:
//     req[1] rises during a requester-0 draw -> served after ack[0], with 1 IDLE cycle between.
//     No pixel overlap.
//   T6 stability:
//     sel0 and x0 changed mid-draw -> output pixels unchanged from the latched values.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// Arbitrates two sprite-draw requesters and streams the granted sprite from the
// shared image ROM to the VGA adapter, one pixel per cycle, clipping off-screen pixels.
module sprite_draw_scheduler #(
    parameter int SPR_W    = 160,
    parameter int SPR_H    = 120,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req,
    input  logic [7:0]  sel0,
    input  logic [7:0]  sel1,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [6:0]  y0,
    input  logic [6:0]  y1,
    output logic [1:0]  ack,
    output logic        busy,
    output logic [14:0] mem_addr,
    output logic [7:0]  chip_sel,
    input  logic [2:0]  mem_q,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        plot,
    output logic [1:0]  dbg_state
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Handshake: a requester raises req[i] with sel/x/y stable and holds it
    // until the one-cycle ack[i] pulse; any req level seen in IDLE is a new request.

    state_t          r_state;
    state_t          w_next_state;
    logic            r_last_grant;
    logic            r_grant;
    logic [7:0]      r_sel;
    logic [7:0]      r_ox;
    logic [6:0]      r_oy;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [14:0]     r_mem_addr;
    logic [7:0]      r_chip_sel;
    logic [7:0]      r_vga_x;
    logic [6:0]      r_vga_y;
    logic            r_plot;
    logic            r_pix_v;

    logic            w_grant_id;
    logic            w_last_px;
    logic [8:0]      w_sum_x;
    logic [7:0]      w_sum_y;
    logic            w_in_bounds;

    // On a tie the requester that did not win last time is chosen.
    assign w_grant_id  = (req == 2'b11) ? ~r_last_grant : req[1];
    assign w_last_px   = (r_col == CW'(SPR_W - 1)) && (r_row == RW'(SPR_H - 1));
    assign w_sum_x     = {1'b0, r_ox} + 9'(r_col);
    assign w_sum_y     = {1'b0, r_oy} + 8'(r_row);
    assign w_in_bounds = (w_sum_x < 9'(SCREEN_W)) && (w_sum_y < 8'(SCREEN_H));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (req != 2'b00) w_next_state = S_DRAW;
            S_DRAW:  if (w_last_px) w_next_state = S_FLUSH;
            S_FLUSH: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // The pixel coordinates are registered on the same edge the ROM samples the
    // address, so they line up with mem_q in the following cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_sel        <= '0;
            r_ox         <= '0;
            r_oy         <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_mem_addr   <= '0;
            r_chip_sel   <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_plot       <= 1'b0;
            r_pix_v      <= 1'b0;
        end else begin
            r_plot  <= 1'b0;
            r_pix_v <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_mem_addr <= '0;
                    r_chip_sel <= '0;
                    if (req != 2'b00) begin
                        r_grant    <= w_grant_id;
                        r_sel      <= w_grant_id ? sel1 : sel0;
                        r_ox       <= w_grant_id ? x1 : x0;
                        r_oy       <= w_grant_id ? y1 : y0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_chip_sel <= w_grant_id ? sel1 : sel0;
                    end
                end
                S_DRAW: begin
                    r_vga_x <= w_sum_x[7:0];
                    r_vga_y <= w_sum_y[6:0];
                    r_pix_v <= 1'b1;
                    r_plot  <= w_in_bounds;
                    if (w_last_px) begin
                        r_chip_sel <= '0;
                    end else begin
                        r_mem_addr <= r_mem_addr + 15'd1;
                        if (r_col == CW'(SPR_W - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                end
                S_DONE: begin
                    r_last_grant <= r_grant;
                    r_mem_addr   <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign ack        = (r_state == S_DONE) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = (r_state != S_IDLE);
    assign mem_addr   = r_mem_addr;
    assign chip_sel   = r_chip_sel;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_pix_v ? mem_q : 3'd0;
    assign plot       = r_plot;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler with a 4x2 sprite and a ROM model
// that returns addr[2:0] one cycle after the address.
module tb_sprite_draw_scheduler;

    localparam int TW = 4;
    localparam int TH = 2;
    localparam int NPIX = TW * TH;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req;
    logic [7:0]  sel0, sel1, x0, x1;
    logic [6:0]  y0, y1;
    logic [1:0]  ack;
    logic        busy;
    logic [14:0] mem_addr;
    logic [7:0]  chip_sel;
    logic [2:0]  mem_q = 3'd0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_ack0 = 0, n_ack1 = 0, n_busy = 0, n_cs = 0;
    logic [7:0]  cs_watch = 8'd0;
    logic [17:0] px_q[$];
    logic [17:0] exp_q[$];

    sprite_draw_scheduler #(
        .SPR_W(TW), .SPR_H(TH), .SCREEN_W(160), .SCREEN_H(120)
    ) dut (
        .clk(clk), .resetn(resetn), .req(req),
        .sel0(sel0), .sel1(sel1), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .ack(ack), .busy(busy), .mem_addr(mem_addr), .chip_sel(chip_sel),
        .mem_q(mem_q), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_q <= mem_addr[2:0];
        cyc   <= cyc + 1;
    end

    always @(negedge clk) begin
        if (plot) px_q.push_back({vga_x, vga_y, vga_colour});
        if (ack[0]) n_ack0++;
        if (ack[1]) n_ack1++;
        if (busy) n_busy++;
        if (chip_sel != 8'd0 && chip_sel == cs_watch) n_cs++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        px_q.delete();
        exp_q.delete();
        n_ack0 = 0;
        n_ack1 = 0;
        n_busy = 0;
        n_cs   = 0;
    endtask

    // Reference pixels for one draw: address k holds colour k, laid out row-major.
    task automatic build_exp(input int ox, input int oy);
        for (int k = 0; k < NPIX; k++) begin
            int sx = ox + (k % TW);
            int sy = oy + (k / TW);
            if (sx < 160 && sy < 120) exp_q.push_back({8'(sx), 7'(sy), 3'(k)});
        end
    endtask

    task automatic wait_ack(input int which, input string tag);
        int n = 0;
        while (ack[which] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check($sformatf("%s_ack%0d", tag, which), 32'(ack[which]), 32'd1);
    endtask

    task automatic compare_pixels(input string tag);
        check($sformatf("%s_npix", tag), px_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < px_q.size()) check($sformatf("%s_pix%0d", tag, i), 32'(px_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req    = 2'b00;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        resetn = 1'b0;
        req = 2'b00;
        sel0 = 8'd0; sel1 = 8'd0; x0 = 8'd0; x1 = 8'd0; y0 = 7'd0; y1 = 7'd0;
        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_cs", 32'(chip_sel), 32'd0);
        check("rst_vx", 32'(vga_x), 32'd0);
        check("rst_vy", 32'(vga_y), 32'd0);
        check("rst_col", 32'(vga_colour), 32'd0);
        resetn = 1'b1;
        tick();

        // single draw
        clear_logs();
        sel0 = 8'd5; x0 = 8'd10; y0 = 7'd20; cs_watch = 8'd5;
        build_exp(10, 20);
        c0 = cyc;
        req = 2'b01;
        wait_ack(0, "t1");
        check("t1_latency", cyc - c0, NPIX + 2);
        req = 2'b00;
        tick();
        tick();
        check("t1_busy_cycles", n_busy, NPIX + 2);
        check("t1_ack_count", n_ack0, 1);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_cs_cycles", n_cs, NPIX);
        compare_pixels("t1");

        // tie from reset, then round robin
        do_reset();
        clear_logs();
        sel0 = 8'd1; x0 = 8'd0; y0 = 7'd0;
        sel1 = 8'd13; x1 = 8'd50; y1 = 7'd60;
        build_exp(0, 0);
        build_exp(50, 60);
        build_exp(0, 0);
        req = 2'b11;
        wait_ack(0, "t2a");
        tick();
        wait_ack(1, "t2b");
        tick();
        wait_ack(0, "t2c");
        req = 2'b00;
        tick();
        tick();
        check("t2_ack0_count", n_ack0, 2);
        check("t2_ack1_count", n_ack1, 1);
        compare_pixels("t2");

        // clipping at the bottom-right corner
        clear_logs();
        sel0 = 8'd2; x0 = 8'd158; y0 = 7'd119;
        build_exp(158, 119);
        req = 2'b01;
        wait_ack(0, "t3");
        req = 2'b00;
        tick();
        tick();
        check("t3_ack_count", n_ack0, 1);
        compare_pixels("t3");

        // reset in the middle of a draw
        clear_logs();
        sel0 = 8'd4; x0 = 8'd30; y0 = 7'd40;
        req = 2'b01;
        for (int n = 0; n < 40 && px_q.size() < 3; n++) tick();
        check("t4_third_plot", px_q.size(), 3);
        resetn = 1'b0;
        tick();
        check("t4_plot_rst", 32'(plot), 32'd0);
        check("t4_busy_rst", 32'(busy), 32'd0);
        check("t4_ack_rst", 32'(ack), 32'd0);
        check("t4_no_ack", n_ack0, 0);
        resetn = 1'b1;
        px_q.delete();
        build_exp(30, 40);
        wait_ack(0, "t4");
        req = 2'b00;
        tick();
        tick();
        check("t4_ack_count", n_ack0, 1);
        compare_pixels("t4");

        // late request from requester 1
        clear_logs();
        sel0 = 8'd3; x0 = 8'd0; y0 = 7'd0;
        sel1 = 8'd14; x1 = 8'd100; y1 = 7'd100;
        build_exp(0, 0);
        build_exp(100, 100);
        req = 2'b01;
        repeat (3) tick();
        req = 2'b11;
        wait_ack(0, "t5a");
        req = 2'b10;
        tick();
        check("t5_idle_gap", 32'(busy), 32'd0);
        tick();
        check("t5_regrant", 32'(busy), 32'd1);
        wait_ack(1, "t5b");
        req = 2'b00;
        tick();
        tick();
        check("t5_ack1_count", n_ack1, 1);
        compare_pixels("t5");

        // inputs changed mid-draw are ignored
        clear_logs();
        sel0 = 8'd7; x0 = 8'd60; y0 = 7'd10; cs_watch = 8'd7;
        build_exp(60, 10);
        req = 2'b01;
        tick();
        tick();
        sel0 = 8'd9; x0 = 8'd80; y0 = 7'd5;
        wait_ack(0, "t6");
        req = 2'b00;
        tick();
        tick();
        check("t6_cs_cycles", n_cs, NPIX);
        compare_pixels("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
